// File: rtl/treasure_frame_ctrl.sv
// Frame-level sequencer for the treasure-colour image processor: syncs to a frame
// boundary, majority-votes N_FRAMES per-frame verdicts and reports via valid/ack.
module treasure_frame_ctrl #(
    parameter int unsigned N_FRAMES    = 8,
    parameter int unsigned MIN_VOTES   = 5,
    parameter logic [23:0] ACK_TIMEOUT = 24'd2_500_000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic       VSYNC_NEG,
    input  logic [2:0] FRAME_RESULT,
    input  logic       ACK,
    output logic       PROC_EN,
    output logic [2:0] RESULT_OUT,
    output logic       RESULT_VALID,
    output logic       BUSY,
    output logic [7:0] FRAME_CNT,
    output logic       TIMEOUT_ERR
);

    localparam logic [7:0] N_FRAMES_B  = 8'(N_FRAMES);
    localparam logic [7:0] MIN_VOTES_B = 8'(MIN_VOTES);
    localparam logic [2:0] CODE_RED    = 3'b010;
    localparam logic [2:0] CODE_BLUE   = 3'b100;
    localparam logic [2:0] CODE_NONE   = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_ACCUM,
        S_DECIDE,
        S_REPORT
    } state_t;

    state_t      state_q, state_d;
    logic        vs_q;
    logic        sample_q, sample_d;
    logic [7:0]  red_cnt_q, red_cnt_d;
    logic [7:0]  blue_cnt_q, blue_cnt_d;
    logic [7:0]  none_cnt_q, none_cnt_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [23:0] tmo_q, tmo_d;
    logic [2:0]  result_q, result_d;
    logic        timeout_err;
    logic        fe;

    // vs_q resets high so a VSYNC_NEG already high at release is not seen as an edge
    assign fe = VSYNC_NEG & ~vs_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            vs_q        <= 1'b1;
            sample_q    <= 1'b0;
            red_cnt_q   <= '0;
            blue_cnt_q  <= '0;
            none_cnt_q  <= '0;
            frame_cnt_q <= '0;
            tmo_q       <= '0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            vs_q        <= VSYNC_NEG;
            sample_q    <= sample_d;
            red_cnt_q   <= red_cnt_d;
            blue_cnt_q  <= blue_cnt_d;
            none_cnt_q  <= none_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            tmo_q       <= tmo_d;
            result_q    <= result_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sample_d    = 1'b0;
        red_cnt_d   = red_cnt_q;
        blue_cnt_d  = blue_cnt_q;
        none_cnt_d  = none_cnt_q;
        frame_cnt_d = frame_cnt_q;
        tmo_d       = tmo_q;
        result_d    = result_q;
        timeout_err = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d     = S_SYNC;
                    red_cnt_d   = '0;
                    blue_cnt_d  = '0;
                    none_cnt_d  = '0;
                    frame_cnt_d = '0;
                end
            end
            S_SYNC: begin
                if (fe) begin
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                // the flag is set even on a sample cycle, so back-to-back frame ends both count
                sample_d = fe;
                if (sample_q) begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    case (FRAME_RESULT)
                        CODE_RED:  red_cnt_d  = red_cnt_q + 8'd1;
                        CODE_BLUE: blue_cnt_d = blue_cnt_q + 8'd1;
                        default:   none_cnt_d = none_cnt_q + 8'd1;
                    endcase
                    if (frame_cnt_d == N_FRAMES_B) begin
                        state_d = S_DECIDE;
                    end
                end
            end
            S_DECIDE: begin
                if (red_cnt_q >= MIN_VOTES_B) begin
                    result_d = CODE_RED;
                end else if (blue_cnt_q >= MIN_VOTES_B) begin
                    result_d = CODE_BLUE;
                end else begin
                    result_d = CODE_NONE;
                end
                tmo_d   = '0;
                state_d = S_REPORT;
            end
            S_REPORT: begin
                if (ACK) begin
                    state_d = S_IDLE;
                end else if (tmo_q == ACK_TIMEOUT - 24'd1) begin
                    state_d     = S_IDLE;
                    timeout_err = 1'b1;
                    result_d    = '0;
                end else begin
                    tmo_d = tmo_q + 24'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign PROC_EN      = (state_q == S_ACCUM);
    assign BUSY         = (state_q != S_IDLE);
    assign RESULT_VALID = (state_q == S_REPORT);
    assign RESULT_OUT   = result_q;
    assign FRAME_CNT    = frame_cnt_q;
    assign TIMEOUT_ERR  = timeout_err;

endmodule

// File: tb/tb_treasure_frame_ctrl.sv
// Self-checking bench for treasure_frame_ctrl: table-driven measurements with a
// result scoreboard, plus timeout, held-START and mid-measurement reset sequences.
module tb_treasure_frame_ctrl;

    localparam int unsigned NF = 10;
    localparam int unsigned MV = 5;
    localparam logic [23:0] TO = 24'd100;

    logic       CLK;
    logic       RESET;
    logic       START;
    logic       VSYNC_NEG;
    logic [2:0] FRAME_RESULT;
    logic       ACK;
    logic       PROC_EN;
    logic [2:0] RESULT_OUT;
    logic       RESULT_VALID;
    logic       BUSY;
    logic [7:0] FRAME_CNT;
    logic       TIMEOUT_ERR;

    treasure_frame_ctrl #(
        .N_FRAMES   (NF),
        .MIN_VOTES  (MV),
        .ACK_TIMEOUT(TO)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .START       (START),
        .VSYNC_NEG   (VSYNC_NEG),
        .FRAME_RESULT(FRAME_RESULT),
        .ACK         (ACK),
        .PROC_EN     (PROC_EN),
        .RESULT_OUT  (RESULT_OUT),
        .RESULT_VALID(RESULT_VALID),
        .BUSY        (BUSY),
        .FRAME_CNT   (FRAME_CNT),
        .TIMEOUT_ERR (TIMEOUT_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [9:0][2:0] fr;
        logic [2:0]      exp;
        logic [7:0]      ack_dly;
    } vec_t;

    vec_t       vecs [6];
    logic [2:0] exp_q [$];
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // fe lands on the third edge, the verdict is sampled on the fourth; returns just after it
    task automatic send_frame(input logic [2:0] code);
        VSYNC_NEG    = 1'b0;
        FRAME_RESULT = code;
        cyc();
        cyc();
        VSYNC_NEG = 1'b1;
        cyc();
        cyc();
    endtask

    task automatic start_meas(input bit hold);
        START = 1'b1;
        cyc();
        check("busy_on_start", BUSY, 1);
        check("proc_en_in_sync", PROC_EN, 0);
        if (!hold) START = 1'b0;
    endtask

    task automatic feed(input logic [9:0][2:0] fr, input logic [2:0] exp);
        send_frame(3'b111);
        check("proc_en_after_sync", PROC_EN, 1);
        for (int i = 9; i >= 0; i--) begin
            send_frame(fr[i]);
            if (i == 9) check("frame_cnt_first", FRAME_CNT, 1);
        end
        exp_q.push_back(exp);
        check("frame_cnt_final", FRAME_CNT, NF);
        check("proc_en_decide", PROC_EN, 0);
        check("valid_in_decide", RESULT_VALID, 0);
    endtask

    task automatic get_result();
        int w;
        logic [2:0] e;
        cyc();
        w = 1;
        while (!RESULT_VALID && w < 10) begin
            cyc();
            w++;
        end
        check("valid_latency", w, 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'bxxx;
        check("result_out", RESULT_OUT, e);
    endtask

    task automatic ack_after(input int d, input logic [2:0] e);
        int drops;
        drops = 0;
        for (int i = 0; i < d; i++) begin
            cyc();
            if (!RESULT_VALID) drops++;
        end
        check("valid_held", drops, 0);
        ACK = 1'b1;
        cyc();
        ACK = 1'b0;
        check("valid_after_ack", RESULT_VALID, 0);
        check("busy_after_ack", BUSY, 0);
        check("result_held", RESULT_OUT, e);
    endtask

    task automatic wait_to_cycle_100();
        int errs;
        errs = 0;
        for (int k = 1; k < 100; k++) begin
            errs += int'(TIMEOUT_ERR);
            cyc();
        end
        check("tmo_early", errs, 0);
        check("valid_cycle100", RESULT_VALID, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_proc_en"}, PROC_EN, 0);
        check({tag, "_result_out"}, RESULT_OUT, 0);
        check({tag, "_valid"}, RESULT_VALID, 0);
        check({tag, "_busy"}, BUSY, 0);
        check({tag, "_frame_cnt"}, FRAME_CNT, 0);
        check({tag, "_tmo_err"}, TIMEOUT_ERR, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int pe;
        vecs[0] = '{fr: {10{3'b010}}, exp: 3'b010, ack_dly: 8'd5};
        vecs[1] = '{fr: {3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b111, 3'b010, 3'b010, 3'b111, 3'b111},
                    exp: 3'b100, ack_dly: 8'd0};
        vecs[2] = '{fr: {3'b010, 3'b100, 3'b010, 3'b100, 3'b010, 3'b111, 3'b100, 3'b010, 3'b111, 3'b010},
                    exp: 3'b010, ack_dly: 8'd2};
        vecs[3] = '{fr: {3'b010, 3'b010, 3'b100, 3'b100, 3'b111, 3'b010, 3'b100, 3'b010, 3'b100, 3'b111},
                    exp: 3'b111, ack_dly: 8'd1};
        vecs[4] = '{fr: {3'b010, 3'b100, 3'b010, 3'b100, 3'b010, 3'b100, 3'b010, 3'b100, 3'b010, 3'b100},
                    exp: 3'b010, ack_dly: 8'd3};
        vecs[5] = '{fr: {3'b010, 3'b010, 3'b010, 3'b010, 3'b011, 3'b110, 3'b000, 3'b100, 3'b100, 3'b111},
                    exp: 3'b111, ack_dly: 8'd1};

        RESET        = 1'b1;
        START        = 1'b0;
        VSYNC_NEG    = 1'b0;
        FRAME_RESULT = 3'b111;
        ACK          = 1'b0;
        cyc();
        cyc();
        check_reset_vals("por");
        RESET = 1'b0;
        cyc();

        for (int k = 0; k < 6; k++) begin
            start_meas(1'b0);
            feed(vecs[k].fr, vecs[k].exp);
            get_result();
            ack_after(int'(vecs[k].ack_dly), vecs[k].exp);
        end

        // no ACK: expiry on the 100th REPORT cycle
        start_meas(1'b0);
        feed({10{3'b100}}, 3'b100);
        get_result();
        wait_to_cycle_100();
        check("tmo_pulse", TIMEOUT_ERR, 1);
        cyc();
        check("tmo_single_pulse", TIMEOUT_ERR, 0);
        check("tmo_busy", BUSY, 0);
        check("tmo_result_cleared", RESULT_OUT, 0);
        check("tmo_valid", RESULT_VALID, 0);

        // ACK coinciding with expiry wins
        start_meas(1'b0);
        feed({10{3'b010}}, 3'b010);
        get_result();
        wait_to_cycle_100();
        ACK = 1'b1;
        #1;
        check("ack_wins_no_err", TIMEOUT_ERR, 0);
        cyc();
        ACK = 1'b0;
        check("ack_wins_busy", BUSY, 0);
        check("ack_wins_result", RESULT_OUT, 3'b010);

        // START held high through the whole measurement and REPORT
        start_meas(1'b1);
        feed(vecs[0].fr, vecs[0].exp);
        get_result();
        ACK = 1'b1;
        cyc();
        ACK = 1'b0;
        check("held_idle_gap", BUSY, 0);
        cyc();
        check("held_restart", BUSY, 1);
        check("held_frame_cnt_clear", FRAME_CNT, 0);
        START = 1'b0;
        send_frame(3'b111);
        for (int i = 0; i < 3; i++) send_frame(3'b010);
        check("mid_frame_cnt", FRAME_CNT, 3);
        check("mid_proc_en", PROC_EN, 1);

        // asynchronous reset in the middle of ACCUM
        #2;
        RESET     = 1'b1;
        VSYNC_NEG = 1'b1;
        #1;
        check_reset_vals("async");
        cyc();
        cyc();
        START = 1'b1;
        RESET = 1'b0;
        cyc();
        check("post_rst_busy", BUSY, 1);
        START = 1'b0;
        pe = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            pe += int'(PROC_EN);
        end
        check("post_rst_no_fe", pe, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
